dmem_responder: RTL and testbench

Multi-cycle data-memory responder. It is the target end of the pipeline's load/store port, and replaces the single-cycle data memory for latency and stall testing. It accepts one request at a time over a valid/ready handshake and completes the access after a fixed programmable latency. It returns read data or an error status over a valid/ready response channel.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_array.sv | 47 ++++
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and address helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int unsigned MIN_LATENCY = 1;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    // Byte address to word index; caller truncates to its index width.
    function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        return addr >> 2;
    endfunction

    // Misaligned, or any byte-address bit above the array range set.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with synchronous write and registered read data.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Every access refreshes the read register; non-read accesses return zero.
    always_comb begin
        rdata_d = rdata_q;
        if (en_i) begin
            rdata_d = re_i ? mem_q[idx_i] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store port target: one outstanding request, fixed latency, valid/ready response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned AW      = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic              busy_o
);

    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (LATENCY < MIN_LATENCY) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be at least %0d", MIN_LATENCY);
    end
    if ((DEPTH < 4) || (AW != $clog2(DEPTH)) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be a power of two >= 4 with AW = log2(DEPTH)");
    end

    state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dmem_req_t req_q, req_d;
    logic      err_q, err_d;
    logic      req_ready_q, req_ready_d;
    logic      resp_valid_q, resp_valid_d;
    logic      busy_q, busy_d;
    logic      acc_en_c;
    logic      err_c;

    assign err_c = addr_err(req_q.addr, AW);

    // Next state, latency count and request capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        acc_en_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    req_d   = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i};
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    acc_en_c = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d        = acc_en_c ? err_c : err_q;
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Erroring accesses neither write nor read the array.
    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (acc_en_c),
        .we_i    (req_q.write && !err_c),
        .re_i    (!req_q.write && !err_c),
        .idx_i   (AW'(word_index(req_q.addr))),
        .wdata_i (req_q.wdata),
        .rdata_o (resp_rdata_o)
    );

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: LATENCY=3 instance for vectors/corners, LATENCY=1 instance for back-to-back.
module tb_dmem_responder;

    localparam int unsigned LAT_A = 3;
    localparam int unsigned LAT_B = 1;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_err, a_busy;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err, b_busy;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

    dmem_responder #(.DEPTH(256), .LATENCY(LAT_A), .AW(8)) dut_a (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
        .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
        .resp_rdata_o(a_resp_rdata), .resp_err_o(a_resp_err), .busy_o(a_busy)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(LAT_B), .AW(8)) dut_b (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
        .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err), .busy_o(b_busy)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction on instance A, called at posedge+1 with A idle.
    task automatic do_req(input string nm, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er,
                          input int hold, input bit wig, input logic [31:0] alt_addr,
                          input logic [31:0] alt_wd);
        exp_t e;
        int   n;
        check({nm, " req_ready before"}, 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1;
        a_req_write = wr;
        a_req_addr  = addr;
        a_req_wdata = wd;
        @(posedge clk); #1;
        sb.push_back('{rdata: exp_rd, err: exp_er});
        if (!wig) a_req_valid = 1'b0;
        n = 0;
        while (!a_resp_valid && n < 20) begin
            if (wig) begin
                a_req_write = ~wr;
                a_req_addr  = alt_addr;
                a_req_wdata = alt_wd;
            end
            @(posedge clk); #1;
            n++;
        end
        a_req_valid = 1'b0;
        check({nm, " latency"}, 32'(n), 32'(LAT_A));
        e = sb.pop_front();
        check({nm, " rdata"}, a_resp_rdata, e.rdata);
        check({nm, " err"}, 32'(a_resp_err), 32'(e.err));
        check({nm, " ready/busy in resp"}, {30'd0, a_req_ready, a_busy}, 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
            check({nm, " stall valid/ready"}, {30'd0, a_resp_valid, a_req_ready}, 32'd2);
            check({nm, " stall rdata"}, a_resp_rdata, e.rdata);
        end
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        check({nm, " after hs valid/ready"}, {30'd0, a_resp_valid, a_req_ready}, 32'd1);
        check({nm, " after hs rdata held"}, a_resp_rdata, e.rdata);
    endtask

    vec_t vecs[$];

    initial begin
        exp_t e;
        int   prev;
        rst_i = 1'b0;
        {a_req_valid, a_req_write, a_resp_ready} = '0;
        {b_req_valid, b_req_write, b_resp_ready} = '0;
        a_req_addr = '0; a_req_wdata = '0; b_req_addr = '0; b_req_wdata = '0;

        // write, addr, wdata, exp_rdata, exp_err, hold
        vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 5});
        vecs.push_back('{1'b1, 32'h0,   32'h0BADF00D, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 32'h12,  32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 0});
        vecs.push_back('{1'b1, 32'h13,  32'hFFFFFFFF, 32'h0,        1'b1, 0});
        vecs.push_back('{1'b0, 32'h0,   32'h0,        32'h0BADF00D, 1'b0, 0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0});
        vecs.push_back('{1'b1, 32'h3FC, 32'h11223344, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 32'h3FC, 32'h0,        32'h11223344, 1'b0, 2});
        vecs.push_back('{1'b1, 32'h20,  32'hAAAA5555, 32'h0,        1'b0, 0});

        repeat (3) @(posedge clk);
        #1;
        check("reset a ready/valid/busy", {29'd0, a_req_ready, a_resp_valid, a_busy}, 32'd4);
        check("reset a rdata", a_resp_rdata, 32'd0);
        check("reset a err", 32'(a_resp_err), 32'd0);
        check("reset b ready/valid/busy", {29'd0, b_req_ready, b_resp_valid, b_busy}, 32'd4);
        rst_i = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_req($sformatf("v%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].hold, 1'b0, 32'h0, 32'h0);
        end

        // Reset during WAIT of a store: the write must be dropped.
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h1234;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid busy before reset", 32'(a_busy), 32'd1);
        rst_i = 1'b0;
        #1;
        check("mid reset ready/valid/busy", {29'd0, a_req_ready, a_resp_valid, a_busy}, 32'd4);
        check("mid reset rdata/err", {a_resp_err, a_resp_rdata[30:0]}, 32'd0);
        repeat (4) @(posedge clk);
        #3 rst_i = 1'b1;
        @(posedge clk); #1;
        do_req("load after dropped store", 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0, 0, 1'b0, 32'h0, 32'h0);

        // Request inputs wiggled while busy must be ignored.
        do_req("wiggle load", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b1, 32'h0, 32'h55);
        do_req("wiggle store", 1'b1, 32'h24, 32'h5, 32'h0, 1'b0, 0, 1'b1, 32'h0, 32'h9);
        do_req("wiggle check 0x0", 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 0, 1'b0, 32'h0, 32'h0);
        do_req("wiggle check 0x24", 1'b0, 32'h24, 32'h0, 32'h5, 1'b0, 0, 1'b0, 32'h0, 32'h0);

        // LATENCY=1 back-to-back, valid and resp_ready held high.
        b_req_valid  = 1'b1;
        b_resp_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            b_req_write = (i < 4);
            b_req_addr  = 32'h40 + 32'((i % 4) * 4);
            b_req_wdata = 32'hC0DE0000 + 32'(i % 4);
            @(posedge clk); #1;
            sb.push_back('{rdata: (i < 4) ? 32'h0 : 32'hC0DE0000 + 32'(i % 4), err: 1'b0});
            check($sformatf("b%0d accepted", i), {30'd0, b_busy, b_resp_valid}, 32'd2);
            if (i > 0) check($sformatf("b%0d issue period", i), 32'(cyc - prev), 32'd3);
            prev = cyc;
            @(posedge clk); #1;
            check($sformatf("b%0d resp valid", i), 32'(b_resp_valid), 32'd1);
            e = sb.pop_front();
            check($sformatf("b%0d rdata", i), b_resp_rdata, e.rdata);
            check($sformatf("b%0d err", i), 32'(b_resp_err), 32'(e.err));
            @(posedge clk); #1;
            check($sformatf("b%0d idle after hs", i), {30'd0, b_resp_valid, b_req_ready}, 32'd1);
        end
        b_req_valid  = 1'b0;
        b_resp_ready = 1'b0;

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
